// File: rtl/alu2_slice_sequencer_if.sv
// Handshake bundle between the issuers, the response consumer, the shared 4-bit ALU slice and the sequencer.
// No storage and no latency: it only groups wires.
// Backpressure is carried by the reqN_ready and rsp_ready signals inside the bundle.
//
// Ports / signals:
//   reqN_valid/ready/op/a/b/cin : two request channels (N = 0, 1)
//   rsp_valid/ready/id/result/cout/zero : response channel
//   slice_op/a/b/cin -> slice, slice_f/cout <- slice (combinational)
// Modports: slave = sequencer side, master = issuer/consumer/slice side.
interface alu2_slice_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic           req0_valid;
    logic           req0_ready;
    logic [1:0]     req0_op;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic           req0_cin;

    logic           req1_valid;
    logic           req1_ready;
    logic [1:0]     req1_op;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic           req1_cin;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_cout;
    logic           rsp_zero;

    logic [1:0]     slice_op;
    logic [3:0]     slice_a;
    logic [3:0]     slice_b;
    logic           slice_cin;
    logic [3:0]     slice_f;
    logic           slice_cout;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
        input  rsp_ready, slice_f, slice_cout,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero,
        output slice_op, slice_a, slice_b, slice_cin
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_cin,
        output req1_valid, req1_op, req1_a, req1_b, req1_cin,
        output rsp_ready, slice_f, slice_cout,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero,
        input  slice_op, slice_a, slice_b, slice_cin
    );
endinterface

// File: rtl/alu2_slice_sequencer.sv
// Shares one combinational 4-bit ALU slice between two round-robin requesters, one nibble per cycle, LSB first.
// Latency: accept edge T, NIBBLES RUN cycles, response valid from cycle T+NIBBLES+1; issue interval NIBBLES+2.
// Backpressure: single outstanding op; both reqN_ready low while busy; result held until rsp_ready.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (drops any in-flight operation)
//   bus  : alu2_slice_sequencer_if.slave (request, response and slice channels)
module alu2_slice_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu2_slice_sequencer_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          id_q,     id_d;
    logic [1:0]    op_q,     op_d;
    logic [W-1:0]  a_q,      a_d;
    logic [W-1:0]  b_q,      b_d;
    logic          carry_q,  carry_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [W-1:0]  result_q, result_d;

    logic          gnt0, gnt1;
    logic [3:0]    a_nib, b_nib;
    logic          last_nib;
    logic          in_run, in_done;

    assign in_run   = (state_q == ST_RUN);
    assign in_done  = (state_q == ST_DONE);
    assign last_nib = (idx_q == IW'(NIBBLES - 1));

    // Exactly one winner in IDLE; rr_ptr only matters when both are valid.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ST_IDLE) begin
            gnt0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
            gnt1 = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
        end
    end

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 | gnt1) begin
                    id_d     = gnt1;
                    op_d     = gnt1 ? bus.req1_op  : bus.req0_op;
                    a_d      = gnt1 ? bus.req1_a   : bus.req0_a;
                    b_d      = gnt1 ? bus.req1_b   : bus.req0_b;
                    carry_d  = gnt1 ? bus.req1_cin : bus.req0_cin;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IW'(n)) begin
                        result_d[4*n +: 4] = bus.slice_f;
                    end
                end
                carry_d = bus.slice_cout;
                // Park idx at 0 after the top nibble so it never exceeds NIBBLES-1.
                if (last_nib) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    rr_ptr_d = ~id_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            id_q     <= 1'b0;
            op_q     <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Slice inputs are forced to zero outside RUN so the shared slice sees no stale operands.
    assign bus.slice_op   = in_run ? op_q    : 2'd0;
    assign bus.slice_a    = in_run ? a_nib   : 4'd0;
    assign bus.slice_b    = in_run ? b_nib   : 4'd0;
    assign bus.slice_cin  = in_run & carry_q;

    // Response fields are only meaningful in DONE; gating keeps them at 0 otherwise.
    assign bus.rsp_valid  = in_done;
    assign bus.rsp_id     = in_done & id_q;
    assign bus.rsp_result = in_done ? result_q : '0;
    assign bus.rsp_cout   = in_done & carry_q;
    assign bus.rsp_zero   = in_done & (result_q == '0);
endmodule
